// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if
//   Groups the PLL supervisor's status and control signals.
//   slave  : supervisor side (samples Locked/Relock_Req, drives everything else)
//   master : PLL wrapper / system side
// Signals:
//   Locked        PLL lock, asynchronous to the supervisor clock
//   Relock_Req    single-cycle request to restart the lock sequence
//   PLL_Reset     active-high PLL reset
//   Domain_Reset  active-high per-domain resets, bit 0 released first
//   Ready         all domains released and lock held
//   Fault         relock retries exhausted
//   Lock_Lost     one-cycle pulse on lock loss during RELEASE/RUN
//   Retry_Count   failed attempts in the current episode
interface pll_lock_supervisor_if #(
  parameter int NUM_DOMAINS = 2,
  parameter int MAX_RETRIES = 3
);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic                   Locked;
  logic                   Relock_Req;
  logic                   PLL_Reset;
  logic [NUM_DOMAINS-1:0] Domain_Reset;
  logic                   Ready;
  logic                   Fault;
  logic                   Lock_Lost;
  logic [RETRY_W-1:0]     Retry_Count;

  modport master (
    output Locked, Relock_Req,
    input  PLL_Reset, Domain_Reset, Ready, Fault, Lock_Lost, Retry_Count
  );

  modport slave (
    input  Locked, Relock_Req,
    output PLL_Reset, Domain_Reset, Ready, Fault, Lock_Lost, Retry_Count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Runs on the PLL reference clock. Holds the PLL in reset, qualifies
//   Locked with a stability window, then releases the downstream domain
//   resets one at a time with a fixed gap. Lock loss and lock timeouts
//   restart the sequence; too many consecutive failures park it in FAULT
//   until Relock_Req or nReset.
// Ports:
//   Clk     reference clock (same clock that feeds the PLL)
//   nReset  synchronous active-low reset
//   sup     pll_lock_supervisor_if.slave (Locked, Relock_Req in;
//           PLL_Reset, Domain_Reset, Ready, Fault, Lock_Lost, Retry_Count out)
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS        = 2,
  parameter int PLL_RESET_CYCLES   = 8,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int RELEASE_GAP        = 16,
  parameter int MAX_RETRIES        = 3
) (
  input logic                  Clk,
  input logic                  nReset,
  pll_lock_supervisor_if.slave sup
);

  localparam int RST_W    = $clog2(PLL_RESET_CYCLES + 1);
  localparam int TIMER_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GAP_W    = $clog2(RELEASE_GAP + 1);
  localparam int RETRY_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [RST_W-1:0]    RST_LAST   = RST_W'(PLL_RESET_CYCLES - 1);
  localparam logic [TIMER_W-1:0]  TIMER_MAX  = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(LOCK_STABLE_CYCLES);
  localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'(RELEASE_GAP - 1);
  localparam logic [RETRY_W-1:0]  RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAULT
  } state_t;

  state_t                 state;
  logic                   locked_m;
  logic                   locked_s;
  logic [RST_W-1:0]       rst_cnt;
  logic [TIMER_W-1:0]     timer;
  logic [STABLE_W-1:0]    stable;
  logic [GAP_W-1:0]       gap;
  logic [RETRY_W-1:0]     retry;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   ready;
  logic                   fault;
  logic                   lock_lost;

  logic [TIMER_W-1:0]     timer_nx;
  logic [STABLE_W-1:0]    stable_nx;
  logic [NUM_DOMAINS-1:0] dom_nx;
  logic                   stable_done;
  logic                   timed_out;
  logic                   relock;
  logic                   lost;
  logic                   failed;

  assign sup.PLL_Reset    = pll_rst;
  assign sup.Domain_Reset = dom_rst;
  assign sup.Ready        = ready;
  assign sup.Fault        = fault;
  assign sup.Lock_Lost    = lock_lost;
  assign sup.Retry_Count  = retry;

  always_comb begin
    timer_nx    = (timer == TIMER_MAX) ? timer : timer + 1'b1;
    stable_nx   = '0;
    if (locked_s) stable_nx = (stable == STABLE_MAX) ? stable : stable + 1'b1;
    // Domains release in ascending order, so clearing the next bit is a
    // left shift of the all-ones pattern; zero after the shift means the
    // top bit is the one being released now.
    dom_nx      = dom_rst << 1;
    stable_done = (stable_nx == STABLE_MAX);
    timed_out   = (timer_nx == TIMER_MAX);
    relock      = sup.Relock_Req && (state != PLL_RST);
    lost        = !locked_s && ((state == RELEASE) || (state == RUN));
    // Stable completion beats a coincident timeout; lock loss in RELEASE
    // counts against the retry budget like a timeout does.
    failed      = ((state == WAIT_LOCK) && timed_out && !stable_done) ||
                  ((state == RELEASE) && lost);
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      locked_m  <= 1'b0;
      locked_s  <= 1'b0;
      state     <= PLL_RST;
      rst_cnt   <= '0;
      timer     <= '0;
      stable    <= '0;
      gap       <= '0;
      retry     <= '0;
      pll_rst   <= 1'b1;
      dom_rst   <= '1;
      ready     <= 1'b0;
      fault     <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      locked_m  <= sup.Locked;
      locked_s  <= locked_m;
      lock_lost <= 1'b0;

      if (relock || (lost && (state == RUN))) begin
        // Fresh episode: either an explicit request or a lock drop after
        // the system was fully up.
        state     <= PLL_RST;
        rst_cnt   <= '0;
        timer     <= '0;
        stable    <= '0;
        retry     <= '0;
        pll_rst   <= 1'b1;
        dom_rst   <= '1;
        ready     <= 1'b0;
        fault     <= 1'b0;
        lock_lost <= !relock;
      end else if (failed) begin
        rst_cnt   <= '0;
        timer     <= '0;
        stable    <= '0;
        pll_rst   <= 1'b1;
        dom_rst   <= '1;
        ready     <= 1'b0;
        lock_lost <= lost;
        if (retry < RETRY_MAX) begin
          retry <= retry + 1'b1;
          state <= PLL_RST;
        end else begin
          state <= FAULT;
          fault <= 1'b1;
        end
      end else begin
        case (state)
          PLL_RST: begin
            if (rst_cnt == RST_LAST) begin
              state   <= WAIT_LOCK;
              pll_rst <= 1'b0;
              timer   <= '0;
              stable  <= '0;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            timer  <= timer_nx;
            stable <= stable_nx;
            if (stable_done) begin
              state <= RELEASE;
              gap   <= '0;
            end
          end
          RELEASE: begin
            if (gap == GAP_LAST) begin
              gap     <= '0;
              dom_rst <= dom_nx;
              if (dom_nx == '0) state <= RUN;
            end else begin
              gap <= gap + 1'b1;
            end
          end
          RUN: begin
            ready <= 1'b1;
          end
          FAULT: begin
            pll_rst <= 1'b1;
            dom_rst <= '1;
            fault   <= 1'b1;
          end
          default: begin
            state <= PLL_RST;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed bench for pll_lock_supervisor with NUM_DOMAINS=3,
//   PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=64,
//   RELEASE_GAP=4, MAX_RETRIES=2. Event times are measured in clock edges
//   from the edge that started the current sequence.
module tb_pll_lock_supervisor;

  localparam int ND  = 3;
  localparam int PRC = 4;
  localparam int LSC = 8;
  localparam int LTO = 64;
  localparam int RG  = 4;
  localparam int MR  = 2;

  logic Clk    = 1'b0;
  logic nReset = 1'b0;

  pll_lock_supervisor_if #(.NUM_DOMAINS(ND), .MAX_RETRIES(MR)) sup ();

  pll_lock_supervisor #(
    .NUM_DOMAINS        (ND),
    .PLL_RESET_CYCLES   (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT       (LTO),
    .RELEASE_GAP        (RG),
    .MAX_RETRIES        (MR)
  ) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .sup    (sup)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Lock_Lost is high for whole cycles, so counting negedge samples gives
  // pulse count times width.
  int ll_pulses = 0;
  always @(negedge Clk) if (sup.Lock_Lost === 1'b1) ll_pulses <= ll_pulses + 1;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return sup.PLL_Reset;
      1:       return sup.Domain_Reset[0];
      2:       return sup.Domain_Reset[1];
      3:       return sup.Domain_Reset[2];
      4:       return sup.Ready;
      5:       return sup.Fault;
      6:       return sup.Lock_Lost;
      default: return 1'bx;
    endcase
  endfunction

  // Returns the edge count at which sig(sel) first equals val, or -1.
  task automatic wait_until(input int sel, input logic val, input int budget,
                            output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge Clk);
      #1;
      if (sig(sel) === val) begin
        hit = 1'b1;
        at  = cyc;
      end
    end
  endtask

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel, at, r, t, d, ll0;

    sup.Locked     = 1'b1;
    sup.Relock_Req = 1'b0;
    nReset         = 1'b0;
    repeat (3) @(posedge Clk);
    #1;

    // Reset values
    chk("rst_pll_reset", sup.PLL_Reset, 1);
    chk("rst_domain_reset", sup.Domain_Reset, 7);
    chk("rst_ready", sup.Ready, 0);
    chk("rst_fault", sup.Fault, 0);
    chk("rst_lock_lost", sup.Lock_Lost, 0);
    chk("rst_retry", sup.Retry_Count, 0);

    // Nominal, with a Relock_Req inside PLL_RST that must be ignored
    nReset = 1'b1;
    rel    = cyc;
    ll0    = ll_pulses;
    at_cycle(rel + 1);
    sup.Relock_Req = 1'b1;
    at_cycle(rel + 2);
    sup.Relock_Req = 1'b0;
    wait_until(0, 1'b0, 20, at);
    chk("nom_pll_reset_fall", at - rel, 4);
    wait_until(1, 1'b0, 40, at);
    chk("nom_dr0_fall", at - rel, 16);
    wait_until(2, 1'b0, 10, at);
    chk("nom_dr1_fall", at - rel, 20);
    wait_until(3, 1'b0, 10, at);
    chk("nom_dr2_fall", at - rel, 24);
    wait_until(4, 1'b1, 10, at);
    chk("nom_ready_rise", at - rel, 25);
    chk("nom_retry", sup.Retry_Count, 0);
    chk("nom_domain_reset", sup.Domain_Reset, 0);
    chk("nom_no_lock_lost", ll_pulses - ll0, 0);

    // Chatter: one low cycle after six stable cycles restarts qualification
    sup.Locked = 1'b0;
    nReset     = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
    rel    = cyc;
    at_cycle(rel + 2);
    sup.Locked = 1'b1;
    at_cycle(rel + 8);
    sup.Locked = 1'b0;
    at_cycle(rel + 9);
    sup.Locked = 1'b1;
    chk("chat_pll_reset_low", sup.PLL_Reset, 0);
    wait_until(1, 1'b0, 40, at);
    chk("chat_dr0_fall", at - rel, 23);
    wait_until(4, 1'b1, 20, at);
    chk("chat_ready_rise", at - rel, 32);

    // Timeout to fault
    sup.Locked = 1'b0;
    nReset     = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
    rel    = cyc;
    wait_until(0, 1'b0, 10, at);
    chk("to_pulse0_fall", at - rel, 4);
    wait_until(0, 1'b1, 80, at);
    chk("to_pulse1_rise", at - rel, 68);
    chk("to_retry1", sup.Retry_Count, 1);
    wait_until(0, 1'b0, 10, at);
    chk("to_pulse1_fall", at - rel, 72);
    wait_until(0, 1'b1, 80, at);
    chk("to_pulse2_rise", at - rel, 136);
    chk("to_retry2", sup.Retry_Count, 2);
    wait_until(0, 1'b0, 10, at);
    chk("to_pulse2_fall", at - rel, 140);
    wait_until(5, 1'b1, 80, at);
    chk("to_fault_rise", at - rel, 204);
    chk("to_fault_pll_reset", sup.PLL_Reset, 1);
    chk("to_fault_domain_reset", sup.Domain_Reset, 7);
    chk("to_fault_retry", sup.Retry_Count, 2);
    chk("to_fault_ready", sup.Ready, 0);
    at_cycle(at + 10);
    chk("to_fault_held", sup.Fault, 1);
    chk("to_fault_pll_held", sup.PLL_Reset, 1);

    // Recovery from FAULT via Relock_Req
    sup.Locked     = 1'b1;
    sup.Relock_Req = 1'b1;
    at_cycle(cyc + 1);
    sup.Relock_Req = 1'b0;
    r = cyc;
    chk("rec_fault_clear", sup.Fault, 0);
    chk("rec_retry_clear", sup.Retry_Count, 0);
    chk("rec_pll_reset", sup.PLL_Reset, 1);
    wait_until(0, 1'b0, 20, at);
    chk("rec_pll_reset_fall", at - r, 4);
    wait_until(4, 1'b1, 40, at);
    chk("rec_ready_rise", at - r, 25);

    // Lock loss in RUN
    t          = at;
    ll0        = ll_pulses;
    sup.Locked = 1'b0;
    wait_until(6, 1'b1, 10, at);
    chk("run_loss_latency", at - t, 3);
    chk("run_loss_domain_reset", sup.Domain_Reset, 7);
    chk("run_loss_ready", sup.Ready, 0);
    chk("run_loss_retry", sup.Retry_Count, 0);
    chk("run_loss_pll_reset", sup.PLL_Reset, 1);
    sup.Locked = 1'b1;
    r          = at;
    @(posedge Clk);
    #1;
    chk("run_loss_pulse_end", sup.Lock_Lost, 0);
    chk("run_loss_pulse_count", ll_pulses - ll0, 1);
    wait_until(1, 1'b0, 40, at);
    chk("run_loss_dr0_again", at - r, 16);

    // Lock loss in RELEASE right after bit 0 cleared
    d          = at;
    sup.Locked = 1'b0;
    wait_until(6, 1'b1, 10, at);
    chk("rel_loss_latency", at - d, 3);
    chk("rel_loss_domain_reset", sup.Domain_Reset, 7);
    chk("rel_loss_retry", sup.Retry_Count, 1);
    chk("rel_loss_pll_reset", sup.PLL_Reset, 1);
    chk("rel_loss_fault", sup.Fault, 0);

    // nReset during RELEASE
    sup.Locked = 1'b1;
    r          = at;
    wait_until(1, 1'b0, 40, at);
    chk("mid_dr0_fall", at - r, 16);
    chk("mid_retry_kept", sup.Retry_Count, 1);
    nReset = 1'b0;
    @(posedge Clk);
    #1;
    chk("mid_rst_pll_reset", sup.PLL_Reset, 1);
    chk("mid_rst_domain_reset", sup.Domain_Reset, 7);
    chk("mid_rst_ready", sup.Ready, 0);
    chk("mid_rst_fault", sup.Fault, 0);
    chk("mid_rst_lock_lost", sup.Lock_Lost, 0);
    chk("mid_rst_retry", sup.Retry_Count, 0);
    nReset = 1'b1;
    repeat (2) @(posedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Single-clock supervisor that sits beside a vendor PLL wrapper and runs on that PLL's reference clock. It drives the PLL reset and qualifies the Locked output with a stability window. It releases up to NUM_DOMAINS per-domain resets in a fixed, staggered order, and detects lock loss. It retries relock a bounded number of times before raising Fault. Each clock domain synchronises its own Domain_Reset bit locally.

Parameters:
NUM_DOMAINS, 2, number of downstream reset outputs (1..16)
PLL_RESET_CYCLES, 8, PLL_Reset assertion length per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised Locked-high cycles needed to qualify lock (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before an attempt fails (> LOCK_STABLE_CYCLES)
RELEASE_GAP, 16, cycles between successive domain reset releases (>=1)
MAX_RETRIES, 3, failed attempts tolerated before FAULT (>=0)

Ports:
Clk  in  1  reference clock, the same clock that feeds the PLL
nReset  in  1  synchronous reset, active-low
Locked  in  1  PLL lock, asynchronous to Clk; double-flop synchronised internally (Locked_s)
Relock_Req  in  1  single-cycle request to restart the lock sequence
PLL_Reset  out  1  active-high PLL reset
Domain_Reset  out  NUM_DOMAINS  active-high per-domain resets; bit 0 is released first
Ready  out  1  high when all domains are released and lock is held
Fault  out  1  retries exhausted
Lock_Lost  out  1  one-cycle pulse when lock drops in RELEASE or RUN
Retry_Count  out  clog2(MAX_RETRIES+1)  failed attempts in the current episode

Behaviour:
- Reset (nReset low at a Clk edge): state=PLL_RST. Timers and retries are 0. PLL_Reset=1, Domain_Reset=all 1, Ready=0, Fault=0, Lock_Lost=0, Retry_Count=0. All outputs are registered.
- Locked_s lags Locked by 2 cycles. All decisions use Locked_s only.
- PLL_RST:
  - PLL_Reset=1 for exactly PLL_RESET_CYCLES cycles, then go to WAIT_LOCK.
  - Timeout timer and stable counter are cleared on entry.
- WAIT_LOCK:
  - PLL_Reset=0. The timeout timer increments every cycle.
  - The stable counter increments while Locked_s=1 and clears to 0 on any Locked_s=0.
  - Stable counter reaching LOCK_STABLE_CYCLES -> RELEASE.
  - Timer reaching LOCK_TIMEOUT with lock not yet qualified -> failed attempt.
- Failed attempt:
  - If Retry_Count < MAX_RETRIES: Retry_Count+1, go to PLL_RST.
  - Otherwise go to FAULT with Retry_Count unchanged.
- RELEASE:
  - A gap counter starts at 0 on entry.
  - Each time it reaches RELEASE_GAP-1, the next Domain_Reset bit (ascending index) clears and the counter restarts.
  - After bit NUM_DOMAINS-1 clears -> RUN. Ready=1 on the cycle after the last bit clears.
  - A released bit stays 0 until lock loss, Relock_Req, or reset.
- RUN: Ready=1, all Domain_Reset=0.
- Lock loss (Locked_s=0 in RELEASE or RUN):
  - Next edge: Lock_Lost=1 for one cycle, all Domain_Reset=1, Ready=0, state=PLL_RST.
  - From RUN: Retry_Count clears to 0, starting a new episode.
  - From RELEASE: treated as a failed attempt (retry rule applies; may enter FAULT).
- FAULT: PLL_Reset=1, Domain_Reset=all 1, Fault=1, Ready=0. Only Relock_Req or nReset leaves this state.
- Relock_Req=1 in any state except PLL_RST:
  - Next edge: state=PLL_RST, Retry_Count=0, Fault=0, all Domain_Reset=1, Ready=0. No Lock_Lost pulse.
  - Relock_Req is ignored while in PLL_RST.
- Simultaneous events: nReset > Relock_Req > lock loss > timeout/stable completion.
- WAIT_LOCK stable completion and timeout on the same cycle: stable completion wins.
- Counter widths are clog2(param+1). Counters saturate; they never wrap.

Test Plan:
Bench parameters: NUM_DOMAINS=3, PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=64, RELEASE_GAP=4, MAX_RETRIES=2.
- Nominal: nReset released, Locked=1 constant -> PLL_Reset high exactly 4 cycles after reset release. Domain_Reset[0], [1], [2] fall 4 cycles apart. Ready rises 1 cycle after bit 2 falls. Retry_Count=0, Lock_Lost never pulses.
- Chatter: Locked drops for 1 cycle after 6 high cycles in WAIT_LOCK -> stable counter restarts. RELEASE is entered only after 8 further consecutive high cycles.
- Timeout to fault: Locked held 0 -> three 4-cycle PLL_Reset pulses with Retry_Count stepping 0->1->2, then FAULT. Fault=1, PLL_Reset=1, Domain_Reset=3'b111.
- Lock loss in RUN: drop Locked once Ready=1 -> exactly one Lock_Lost pulse, Domain_Reset=3'b111 and Ready=0 on the same edge, Retry_Count=0. Full sequence repeats.
- Lock loss mid-RELEASE: drop Locked after Domain_Reset[0] clears -> all bits reassert, Retry_Count=1, PLL_RST re-entered.
- Recovery and reset: Relock_Req in FAULT -> Fault=0, Retry_Count=0, nominal sequence completes. nReset low mid-RELEASE -> all outputs at reset values on the next edge.
